// File: rtl/orb_descriptor_collector.sv
// Collects finished BRIEF descriptors from four generators and replays them
// in corner-dispatch order over a valid/ready stream, releasing each hold slot.

module orb_hold_slot #(
    parameter int DESC_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [DESC_W-1:0] desc,
    input  logic              take,
    output logic              hv,
    output logic [DESC_W-1:0] data,
    output logic              drop
);
    // A done on the take cycle refills the slot instead of colliding with it
    assign drop = done & hv & ~take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hv   <= 1'b0;
            data <= '0;
        end else if (done && !drop) begin
            hv   <= 1'b1;
            data <= desc;
        end else if (take) begin
            hv   <= 1'b0;
        end
    end
endmodule

module orb_descriptor_collector #(
    parameter int DESC_W = 256,
    parameter int XY_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [1:0]        issue_gen,
    input  logic [XY_W-1:0]   issue_xy,
    input  logic [3:0]        done,
    input  logic [DESC_W-1:0] desc0,
    input  logic [DESC_W-1:0] desc1,
    input  logic [DESC_W-1:0] desc2,
    input  logic [DESC_W-1:0] desc3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DESC_W-1:0] out_desc,
    output logic [XY_W-1:0]   out_xy,
    output logic [1:0]        out_gen,
    // "release" is a reserved word, hence the prefix
    output logic [3:0]        gen_release,
    output logic [2:0]        pending,
    output logic              err
);
    localparam int NUM_GEN = 4;

    typedef struct packed {
        logic [1:0]      gen;
        logic [XY_W-1:0] xy;
    } ord_t;

    typedef enum logic {EMPTY, FULL} state_t;

    ord_t [NUM_GEN-1:0]               fifo;
    logic [1:0]                       wr_ptr, rd_ptr;
    logic [2:0]                       count, count_nx;
    state_t                           state;
    logic [NUM_GEN-1:0]               hv, drop, take;
    logic [NUM_GEN-1:0][DESC_W-1:0]   slot_data, desc_in;
    ord_t                             head;
    logic                             load, push, overflow;

    assign desc_in  = {desc3, desc2, desc1, desc0};
    assign head     = fifo[rd_ptr];
    assign load     = (count != 3'd0) && hv[head.gen] && (state == EMPTY || out_ready);
    // A pop in the same cycle frees the entry a full-FIFO push needs
    assign push     = issue && (count != 3'd4 || load);
    assign overflow = issue && (count == 3'd4) && !load;
    assign count_nx = count + {2'b0, push} - {2'b0, load};
    assign pending  = count;

    for (genvar g = 0; g < NUM_GEN; g++) begin : g_slot
        assign take[g] = load && (head.gen == 2'(g));
        orb_hold_slot #(.DESC_W(DESC_W)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .done (done[g]),
            .desc (desc_in[g]),
            .take (take[g]),
            .hv   (hv[g]),
            .data (slot_data[g]),
            .drop (drop[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= EMPTY;
            out_valid   <= 1'b0;
            out_desc    <= '0;
            out_xy      <= '0;
            out_gen     <= '0;
            gen_release <= '0;
            err         <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= ord_t'{gen: issue_gen, xy: issue_xy};
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (load)
                rd_ptr <= rd_ptr + 2'd1;
            count       <= count_nx;
            gen_release <= take;
            if (overflow || |drop)
                err <= 1'b1;

            if (load) begin
                state     <= FULL;
                out_valid <= 1'b1;
                out_desc  <= slot_data[head.gen];
                out_xy    <= head.xy;
                out_gen   <= head.gen;
            end else if (state == FULL && out_ready) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_orb_descriptor_collector.sv
// Directed vector bench for orb_descriptor_collector: ordering, backpressure,
// overflow, double-done and asynchronous reset behaviour.

module tb_orb_descriptor_collector;
    localparam int DESC_W = 256;
    localparam int XY_W   = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue;
    logic [1:0]        issue_gen;
    logic [XY_W-1:0]   issue_xy;
    logic [3:0]        done;
    logic [DESC_W-1:0] desc0, desc1, desc2, desc3;
    logic              out_valid, out_ready;
    logic [DESC_W-1:0] out_desc;
    logic [XY_W-1:0]   out_xy;
    logic [1:0]        out_gen;
    logic [3:0]        gen_release;
    logic [2:0]        pending;
    logic              err;
    logic [7:0]        cur_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    orb_descriptor_collector #(.DESC_W(DESC_W), .XY_W(XY_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue),
        .issue_gen   (issue_gen),
        .issue_xy    (issue_xy),
        .done        (done),
        .desc0       (desc0),
        .desc1       (desc1),
        .desc2       (desc2),
        .desc3       (desc3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_desc    (out_desc),
        .out_xy      (out_xy),
        .out_gen     (out_gen),
        .gen_release (gen_release),
        .pending     (pending),
        .err         (err)
    );

    // Each generator's descriptor is tagged with its index and the current tag
    function automatic logic [DESC_W-1:0] mk(input logic [1:0] g, input logic [7:0] t);
        return {t, 232'h0, 6'h0, g, t};
    endfunction

    assign desc0 = mk(2'd0, cur_tag);
    assign desc1 = mk(2'd1, cur_tag);
    assign desc2 = mk(2'd2, cur_tag);
    assign desc3 = mk(2'd3, cur_tag);

    typedef struct {
        logic            rst, iss;
        logic [1:0]      ig;
        logic [XY_W-1:0] ixy;
        logic [3:0]      dn;
        logic [7:0]      tag;
        logic            rdy;
        logic            ev;
        logic [1:0]      eg;
        logic [XY_W-1:0] exy;
        logic [7:0]      etag;
        logic [3:0]      erel;
        logic [2:0]      ep;
        logic            ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input logic r, input logic i, input logic [1:0] ig,
                               input logic [XY_W-1:0] ixy, input logic [3:0] dn,
                               input logic [7:0] tag, input logic rdy, input logic ev,
                               input logic [1:0] eg, input logic [XY_W-1:0] exy,
                               input logic [7:0] etag, input logic [3:0] erel,
                               input logic [2:0] ep, input logic ee);
        vec_t v;
        v.rst = r; v.iss = i; v.ig = ig; v.ixy = ixy; v.dn = dn; v.tag = tag; v.rdy = rdy;
        v.ev = ev; v.eg = eg; v.exy = exy; v.etag = etag; v.erel = erel; v.ep = ep; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DESC_W-1:0] act, input logic [DESC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        issue = 1'b0; issue_gen = '0; issue_xy = '0; done = '0; cur_tag = '0;
    endtask

    task automatic check_out(input string nm, input logic ev, input logic [1:0] eg,
                             input logic [XY_W-1:0] exy, input logic [7:0] etag,
                             input logic [3:0] erel, input logic [2:0] ep, input logic ee,
                             input logic chk_data);
        chk({nm, " out_valid"}, DESC_W'(out_valid), DESC_W'(ev));
        chk({nm, " release"},   DESC_W'(gen_release), DESC_W'(erel));
        chk({nm, " pending"},   DESC_W'(pending), DESC_W'(ep));
        chk({nm, " err"},       DESC_W'(err), DESC_W'(ee));
        if (chk_data) begin
            chk({nm, " out_gen"},  DESC_W'(out_gen), DESC_W'(eg));
            chk({nm, " out_xy"},   DESC_W'(out_xy), DESC_W'(exy));
            chk({nm, " out_desc"}, out_desc, mk(eg, etag));
        end
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        idle();

        // reset state
        tbl.push_back(V(1,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // in-order completion
        tbl.push_back(V(0,1,0,'h10,  4'b0000,0,    1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,1,'h20,  4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,1,2,'h30,  4'b0000,0,    1, 0,0,0,0,0,3,0));
        tbl.push_back(V(0,1,3,'h40,  4'b0000,0,    1, 0,0,0,0,0,4,0));
        tbl.push_back(V(0,0,0,0,     4'b0001,'hA0, 1, 0,0,0,0,0,4,0));
        tbl.push_back(V(0,0,0,0,     4'b0010,'hA1, 1, 1,0,'h10,'hA0,4'b0001,3,0));
        tbl.push_back(V(0,0,0,0,     4'b0100,'hA2, 1, 1,1,'h20,'hA1,4'b0010,2,0));
        tbl.push_back(V(0,0,0,0,     4'b1000,'hA3, 1, 1,2,'h30,'hA2,4'b0100,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,3,'h40,'hA3,4'b1000,0,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // out-of-order completion: gen1 finishes three cycles before gen0
        tbl.push_back(V(0,1,0,'h50,  4'b0000,0,    1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,1,'h60,  4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0010,'hB1, 1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0001,'hB0, 1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,0,'h50,'hB0,4'b0001,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,1,'h60,'hB1,4'b0010,0,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // backpressure: two ready, out_ready low for five cycles
        tbl.push_back(V(0,1,2,'h70,  4'b0000,0,    0, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,3,'h80,  4'b1100,'hC0, 0, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    0, 1,2,'h70,'hC0,4'b0100,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    0, 1,2,'h70,'hC0,4'b0000,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    0, 1,2,'h70,'hC0,4'b0000,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    0, 1,2,'h70,'hC0,4'b0000,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    0, 1,2,'h70,'hC0,4'b0000,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,3,'h80,'hC0,4'b1000,0,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // full FIFO: 5th issue dropped, later issue with a pop accepted
        tbl.push_back(V(0,1,0,'h91,  4'b0000,0,    1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,1,'h92,  4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,1,2,'h93,  4'b0000,0,    1, 0,0,0,0,0,3,0));
        tbl.push_back(V(0,1,3,'h94,  4'b0000,0,    1, 0,0,0,0,0,4,0));
        tbl.push_back(V(0,1,0,'h95,  4'b0000,0,    1, 0,0,0,0,0,4,1));
        tbl.push_back(V(0,0,0,0,     4'b1111,'hD0, 1, 0,0,0,0,0,4,1));
        tbl.push_back(V(0,1,0,'h96,  4'b0000,0,    1, 1,0,'h91,'hD0,4'b0001,4,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,1,'h92,'hD0,4'b0010,3,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,2,'h93,'hD0,4'b0100,2,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,3,'h94,'hD0,4'b1000,1,1));
        tbl.push_back(V(0,0,0,0,     4'b0001,'hD1, 1, 0,0,0,0,0,1,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,0,'h96,'hD1,4'b0001,0,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,1));
        tbl.push_back(V(1,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // double done on slot 2 while gen1 heads the FIFO
        tbl.push_back(V(0,1,1,'hA1,  4'b0000,0,    1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,2,'hA2,  4'b0000,0,    1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0100,'hE0, 1, 0,0,0,0,0,2,0));
        tbl.push_back(V(0,0,0,0,     4'b0100,'hE1, 1, 0,0,0,0,0,2,1));
        tbl.push_back(V(0,0,0,0,     4'b0010,'hE2, 1, 0,0,0,0,0,2,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,1,'hA1,'hE2,4'b0010,1,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,2,'hA2,'hE0,4'b0100,0,1));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,1));
        tbl.push_back(V(1,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));
        // done on slot 2 in the cycle it loads: refill, no err
        tbl.push_back(V(0,1,2,'hB2,  4'b0000,0,    1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0100,'hF0, 1, 0,0,0,0,0,1,0));
        tbl.push_back(V(0,1,2,'hB3,  4'b0100,'hF1, 1, 1,2,'hB2,'hF0,4'b0100,1,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 1,2,'hB3,'hF1,4'b0100,0,0));
        tbl.push_back(V(0,0,0,0,     4'b0000,0,    1, 0,0,0,0,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            rst       = tbl[k].rst;
            issue     = tbl[k].iss;
            issue_gen = tbl[k].ig;
            issue_xy  = tbl[k].ixy;
            done      = tbl[k].dn;
            cur_tag   = tbl[k].tag;
            out_ready = tbl[k].rdy;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].eg, tbl[k].exy, tbl[k].etag,
                      tbl[k].erel, tbl[k].ep, tbl[k].ee, tbl[k].ev | tbl[k].rst);
        end

        // async reset mid-stream: set err, hold a descriptor at the output, then reset
        rst = 1'b0; idle(); out_ready = 1'b0;
        done = 4'b1000; cur_tag = 8'h33;
        @(posedge clk); #1;
        done = 4'b1000; cur_tag = 8'h44;
        @(posedge clk); #1;
        chk("ar err set", DESC_W'(err), DESC_W'(1'b1));
        issue = 1'b1; issue_gen = 2'd0; issue_xy = 'hC0; done = 4'b0001; cur_tag = 8'h55;
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        check_out("ar held", 1'b1, 2'd0, 'hC0, 8'h55, 4'b0001, 3'd0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_out("ar async", 1'b0, 2'd0, '0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b1);
        #1 rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("ar idle", 1'b0, 2'd0, '0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0);
        issue = 1'b1; issue_gen = 2'd3; issue_xy = 'hD3; done = 4'b1000; cur_tag = 8'h77;
        @(posedge clk); #1;
        idle();
        check_out("ar push", 1'b0, 2'd0, '0, 8'h00, 4'b0000, 3'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("ar out", 1'b1, 2'd3, 'hD3, 8'h77, 4'b1000, 3'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_out("ar drain", 1'b0, 2'd0, '0, 8'h00, 4'b0000, 3'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
